// File: rtl/nn_mux_pkg.sv
// Shared definitions for the four-way round-robin mux arbiter.
// Holds the requester count, select width and output-stage state encoding.
package nn_mux_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mux32x4.sv
// Plain 32-bit four-input multiplexer; select picks which input reaches out.
module mux32x4 (
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic [1:0]  select,
    output logic [31:0] out
);

    always_comb begin
        unique case (select)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 32-bit path among four requesters; the
// winner's word is captured into a register and offered with valid/ready.
module mux4_rr_arbiter
    import nn_mux_pkg::*;
#(
    parameter int WIDTH = 32,   // mux32x4 is fixed at 32 bits
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req,
    input  logic [WIDTH-1:0]    in_data0,
    input  logic [WIDTH-1:0]    in_data1,
    input  logic [WIDTH-1:0]    in_data2,
    input  logic [WIDTH-1:0]    in_data3,
    output logic [NREQ-1:0]     ack,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SEL_W-1:0]    out_src,
    output logic [CNT_W-1:0]    xfer_cnt
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0]     out_src_q, out_src_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]      ack_q, ack_d;
    logic [CNT_W-1:0]     xfer_cnt_q, xfer_cnt_d;

    logic [NREQ-1:0]      eff_req;
    logic [SEL_W-1:0]     winner;
    logic [SEL_W-1:0]     cand;
    logic                 found;
    logic                 load;
    logic                 accept;
    logic [31:0]          mux_out;

    // A requester acked this cycle still shows its old req, so mask it.
    assign eff_req = req & ~ack_q;

    always_comb begin
        winner = ptr_q;
        cand   = ptr_q;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ptr_q + SEL_W'(k);
            if (!found && eff_req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    mux32x4 u_mux (
        .in0    (in_data0),
        .in1    (in_data1),
        .in2    (in_data2),
        .in3    (in_data3),
        .select (winner),
        .out    (mux_out)
    );

    assign accept = (state_q == BUSY) && out_ready;
    assign load   = (|eff_req) && ((state_q == IDLE) || out_ready);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        ptr_d      = ptr_q;
        ack_d      = '0;
        xfer_cnt_d = xfer_cnt_q;

        if (accept) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end

        if (load) begin
            out_data_d = mux_out;
            out_src_d  = winner;
            ptr_d      = winner;
            ack_d      = {{(NREQ-1){1'b0}}, 1'b1} << winner;
            state_d    = BUSY;
        end else if (accept) begin
            state_d    = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            out_data_q <= '0;
            out_src_q  <= '0;
            ptr_q      <= SEL_W'(NREQ - 1);
            ack_q      <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign ack       = ack_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = (state_q == BUSY);
    assign xfer_cnt  = xfer_cnt_q;

endmodule
